// File: rtl/vscale_mp_hasti_sram.sv
// N-port HASTI SRAM: zero-wait reads with byte-merge of all pending posted writes,
// one-entry write buffer per port, round-robin commit through a single write port.
module vscale_mp_hasti_sram #(
  parameter int unsigned NPORTS       = 2,
  parameter int unsigned NWORDS       = 65536,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned TRANS_WIDTH  = 2,
  parameter int unsigned BURST_WIDTH  = 3,
  parameter int unsigned PROT_WIDTH   = 4
) (
  input  logic                              hclk,
  input  logic                              hresetn,
  input  logic [NPORTS*ADDR_WIDTH-1:0]      haddr,
  input  logic [NPORTS-1:0]                 hwrite,
  input  logic [NPORTS*SIZE_WIDTH-1:0]      hsize,
  input  logic [NPORTS*BURST_WIDTH-1:0]     hburst,
  input  logic [NPORTS-1:0]                 hmastlock,
  input  logic [NPORTS*PROT_WIDTH-1:0]      hprot,
  input  logic [NPORTS*TRANS_WIDTH-1:0]     htrans,
  input  logic [NPORTS*BUS_WIDTH-1:0]       hwdata,
  output logic [NPORTS*BUS_WIDTH-1:0]       hrdata,
  output logic [NPORTS-1:0]                 hready,
  output logic [NPORTS-1:0]                 hresp
);

  localparam int unsigned NB     = BUS_WIDTH / 8;
  localparam int unsigned MEM_AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned WA_W   = ADDR_WIDTH - 2;

  localparam logic [TRANS_WIDTH-1:0] TRANS_NONSEQ = TRANS_WIDTH'(2);
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_RDATA, S_WDATA, S_ERR1, S_ERR2} state_t;

  logic [BUS_WIDTH-1:0] mem [NWORDS];

  state_t               state    [NPORTS];
  logic [MEM_AW-1:0]    reg_addr [NPORTS];
  logic [1:0]           reg_off  [NPORTS];
  logic [1:0]           reg_size [NPORTS];

  logic [NPORTS-1:0]    buf_valid;
  logic [MEM_AW-1:0]    buf_addr [NPORTS];
  logic [NB-1:0]        buf_mask [NPORTS];
  logic [BUS_WIDTH-1:0] buf_data [NPORTS];

  logic [PW-1:0]        rr_ptr;
  logic                 grant_valid_c;
  logic [PW-1:0]        grant_c;
  logic [NPORTS-1:0]    accept_c;
  logic [NPORTS-1:0]    oor_c;

  logic unused_inputs;
  assign unused_inputs = ^{hburst, hmastlock, hprot, hsize};

  function automatic logic [NB-1:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [NB-1:0] base;
    case (size)
      2'd0:    base = NB'(4'h1);
      2'd1:    base = NB'(4'h3);
      default: base = NB'(4'hf);
    endcase
    return base << off;
  endfunction

  function automatic logic [BUS_WIDTH-1:0] merge_lanes(input logic [BUS_WIDTH-1:0] base,
                                                      input logic [NB-1:0]        mask,
                                                      input logic [BUS_WIDTH-1:0] data);
    logic [BUS_WIDTH-1:0] r;
    r = base;
    for (int b = 0; b < int'(NB); b++) begin
      if (mask[b]) r[b*8 +: 8] = data[b*8 +: 8];
    end
    return r;
  endfunction

  // Round-robin pick of one valid buffer, scanning upward from rr_ptr
  always_comb begin
    logic [PW-1:0] idx;
    grant_valid_c = 1'b0;
    grant_c       = '0;
    idx           = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      idx = PW'((32'(rr_ptr) + 32'(i)) % NPORTS);
      if (!grant_valid_c && buf_valid[idx]) begin
        grant_valid_c = 1'b1;
        grant_c       = idx;
      end
    end
  end

  // Per-port response; read data merges peers' buffers in port order, own buffer last
  always_comb begin
    logic [BUS_WIDTH-1:0] word;
    hready = '1;
    hresp  = '0;
    hrdata = '0;
    word   = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      case (state[p])
        S_ERR1: begin
          hready[p] = 1'b0;
          hresp[p]  = RESP_ERROR;
        end
        S_ERR2: hresp[p] = RESP_ERROR;
        S_WDATA: begin
          if (buf_valid[p] && !(grant_valid_c && grant_c == PW'(p))) hready[p] = 1'b0;
        end
        S_RDATA: begin
          word = mem[reg_addr[p]];
          for (int q = 0; q < int'(NPORTS); q++) begin
            if (q != p && buf_valid[q] && buf_addr[q] == reg_addr[p])
              word = merge_lanes(word, buf_mask[q], buf_data[q]);
          end
          if (buf_valid[p] && buf_addr[p] == reg_addr[p])
            word = merge_lanes(word, buf_mask[p], buf_data[p]);
          hrdata[p*BUS_WIDTH +: BUS_WIDTH] = word;
        end
        default: hresp[p] = RESP_OKAY;
      endcase
    end
  end

  always_comb begin
    accept_c = '0;
    oor_c    = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      accept_c[p] = (htrans[p*TRANS_WIDTH +: TRANS_WIDTH] == TRANS_NONSEQ) && hready[p];
      oor_c[p]    = {2'b00, haddr[p*ADDR_WIDTH+2 +: WA_W]} >= ADDR_WIDTH'(NWORDS);
    end
  end

  // Port FSMs, write buffers and arbiter pointer; a refill on the grant edge wins
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      for (int p = 0; p < int'(NPORTS); p++) begin
        state[p]    <= S_IDLE;
        reg_addr[p] <= '0;
        reg_off[p]  <= '0;
        reg_size[p] <= '0;
        buf_addr[p] <= '0;
        buf_mask[p] <= '0;
        buf_data[p] <= '0;
      end
    end else begin
      if (grant_valid_c) begin
        buf_valid[grant_c] <= 1'b0;
        rr_ptr <= (grant_c == PW'(NPORTS - 1)) ? '0 : grant_c + PW'(1);
      end
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (state[p] == S_WDATA && hready[p]) begin
          buf_valid[p] <= 1'b1;
          buf_addr[p]  <= reg_addr[p];
          buf_mask[p]  <= byte_mask(reg_size[p], reg_off[p]);
          buf_data[p]  <= hwdata[p*BUS_WIDTH +: BUS_WIDTH];
        end
        if (accept_c[p]) begin
          state[p]    <= oor_c[p] ? S_ERR1 : (hwrite[p] ? S_WDATA : S_RDATA);
          reg_addr[p] <= haddr[p*ADDR_WIDTH+2 +: MEM_AW];
          reg_off[p]  <= haddr[p*ADDR_WIDTH +: 2];
          reg_size[p] <= hsize[p*SIZE_WIDTH +: 2];
        end else if (state[p] == S_ERR1) begin
          state[p] <= S_ERR2;
        end else if (state[p] != S_WDATA || hready[p]) begin
          state[p] <= S_IDLE;
        end
      end
    end
  end

  // Single memory write port; the array itself is never reset
  always_ff @(posedge hclk) begin
    if (grant_valid_c)
      mem[buf_addr[grant_c]] <= merge_lanes(mem[buf_addr[grant_c]], buf_mask[grant_c],
                                            buf_data[grant_c]);
  end

endmodule

// File: tb/tb_vscale_mp_hasti_sram.sv
// Directed bench for vscale_mp_hasti_sram: a 2-port instance driven from a cycle table,
// plus a 4-port instance for the multi-buffer lane-merge case.
module tb_vscale_mp_hasti_sram;

  localparam int unsigned NW = 1024;

  logic hclk;
  logic hresetn;

  logic [63:0]  haddr2;
  logic [1:0]   hwrite2;
  logic [5:0]   hsize2;
  logic [5:0]   hburst2;
  logic [1:0]   hmastlock2;
  logic [7:0]   hprot2;
  logic [3:0]   htrans2;
  logic [63:0]  hwdata2;
  logic [63:0]  hrdata2;
  logic [1:0]   hready2;
  logic [1:0]   hresp2;

  logic [127:0] haddr4;
  logic [3:0]   hwrite4;
  logic [11:0]  hsize4;
  logic [11:0]  hburst4;
  logic [3:0]   hmastlock4;
  logic [15:0]  hprot4;
  logic [7:0]   htrans4;
  logic [127:0] hwdata4;
  logic [127:0] hrdata4;
  logic [3:0]   hready4;
  logic [3:0]   hresp4;

  int n_cmp;
  int n_fail;

  vscale_mp_hasti_sram #(.NPORTS(2), .NWORDS(NW)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr2), .hwrite(hwrite2), .hsize(hsize2),
    .hburst(hburst2), .hmastlock(hmastlock2), .hprot(hprot2), .htrans(htrans2),
    .hwdata(hwdata2), .hrdata(hrdata2), .hready(hready2), .hresp(hresp2)
  );

  vscale_mp_hasti_sram #(.NPORTS(4), .NWORDS(NW)) dut4 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr4), .hwrite(hwrite4), .hsize(hsize4),
    .hburst(hburst4), .hmastlock(hmastlock4), .hprot(hprot4), .htrans(htrans4),
    .hwdata(hwdata4), .hrdata(hrdata4), .hready(hready4), .hresp(hresp4)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [1:0]       tr;
    logic [1:0]       wr;
    logic [1:0][31:0] a;
    logic [1:0][2:0]  s;
    logic [1:0][31:0] d;
    logic [1:0]       rdy;
    logic [1:0]       resp;
    logic [1:0]       chk;
    logic [1:0][31:0] rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic [1:0] tr, input logic [1:0] wr,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [2:0] s0, input logic [2:0] s1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] rdy, input logic [1:0] resp,
                             input logic [1:0] chk, input logic [31:0] r0, input logic [31:0] r1);
    vec_t x;
    x.tr = tr;   x.wr = wr;
    x.a[0] = a0; x.a[1] = a1;
    x.s[0] = s0; x.s[1] = s1;
    x.d[0] = d0; x.d[1] = d1;
    x.rdy = rdy; x.resp = resp; x.chk = chk;
    x.rd[0] = r0; x.rd[1] = r1;
    return x;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive2(input vec_t x);
    for (int p = 0; p < 2; p++) begin
      htrans2[p*2 +: 2]  = x.tr[p] ? 2'b10 : 2'b00;
      hwrite2[p]         = x.wr[p];
      haddr2[p*32 +: 32] = x.a[p];
      hsize2[p*3 +: 3]   = x.s[p];
      hwdata2[p*32 +: 32] = x.d[p];
    end
  endtask

  task automatic check2(input vec_t x, input string name);
    check({name, " hready"}, 128'(hready2), 128'(x.rdy));
    check({name, " hresp"}, 128'(hresp2), 128'(x.resp));
    for (int p = 0; p < 2; p++) begin
      if (x.chk[p])
        check($sformatf("%s hrdata%0d", name, p), 128'(hrdata2[p*32 +: 32]), 128'(x.rd[p]));
    end
  endtask

  task automatic apply(input vec_t x, input string name);
    drive2(x);
    @(negedge hclk);
    check2(x, name);
    tick();
  endtask

  task automatic drive4(input int p, input logic ns, input logic wr, input logic [31:0] a,
                        input logic [2:0] s);
    htrans4[p*2 +: 2]  = ns ? 2'b10 : 2'b00;
    hwrite4[p]         = wr;
    haddr4[p*32 +: 32] = a;
    hsize4[p*3 +: 3]   = s;
  endtask

  task automatic idle4();
    htrans4 = '0;
    hwrite4 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] A0 = 32'h0A00_0001, A1 = 32'h0A00_0002, A2 = 32'h0A00_0003;
  localparam logic [31:0] B0 = 32'h0B00_0001, B1 = 32'h0B00_0002, B2 = 32'h0B00_0003;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    hresetn = 1'b0;
    haddr2 = '0; hwrite2 = '0; hsize2 = '0; hburst2 = '0; hmastlock2 = '0; hprot2 = '0;
    htrans2 = '0; hwdata2 = '0;
    haddr4 = '0; hwrite4 = '0; hsize4 = '0; hburst4 = '0; hmastlock4 = '0; hprot4 = '0;
    htrans4 = '0; hwdata4 = '0;

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("reset hready2", 128'(hready2), 128'(2'b11));
    check("reset hresp2", 128'(hresp2), 128'(2'b00));
    check("reset hrdata2", 128'(hrdata2), 128'(0));
    check("reset hready4", 128'(hready4), 128'(4'hf));
    check("reset hresp4", 128'(hresp4), 128'(4'h0));
    check("reset hrdata4", hrdata4, 128'(0));
    hresetn = 1'b1;
    tick();

    // own-write bypass
    vt.push_back(v(2'b01, 2'b01, 'h10, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b01, 2'b00, 'h10, 0, 2, 2, 32'hDEADBEEF, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b01, 32'hDEADBEEF, 0));
    // preload 0x11223344 from port1, then cross-port byte merge
    vt.push_back(v(2'b10, 2'b10, 0, 'h10, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 32'h11223344, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b01, 2'b01, 'h13, 0, 0, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b10, 2'b00, 0, 'h10, 0, 2, 32'hAA000000, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b10, 0, 32'hAA223344));
    vt.push_back(v(2'b01, 2'b00, 'h10, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b01, 32'hAA223344, 0));
    // both ports writing back-to-back; at most one stall cycle each, grants alternate
    vt.push_back(v(2'b11, 2'b11, 'h40, 'h80, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b11, 2'b11, 'h44, 'h84, 2, 2, A0, B0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b11, 2'b11, 'h48, 'h88, 2, 2, A1, B1, 2'b10, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b01, 2'b01, 'h48, 0, 2, 2, A1, B2, 2'b01, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, A2, B2, 2'b10, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, A2, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b11, 2'b00, 'h40, 'h88, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b11, 2'b00, 'h44, 'h84, 2, 2, 0, 0, 2'b11, 2'b00, 2'b11, A0, B2));
    vt.push_back(v(2'b11, 2'b00, 'h48, 'h80, 2, 2, 0, 0, 2'b11, 2'b00, 2'b11, A1, B1));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b11, A2, B0));
    // out-of-range read on port1
    vt.push_back(v(2'b10, 2'b00, 0, 4*NW, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b10, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    // out-of-range write whose low bits alias word 0x10 must not touch it
    vt.push_back(v(2'b01, 2'b01, 4*NW + 'h10, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 32'hFFFFFFFF, 0, 2'b10, 2'b01, 2'b00, 0, 0));
    vt.push_back(v(2'b01, 2'b00, 'h10, 0, 2, 2, 0, 0, 2'b11, 2'b01, 2'b00, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b01, 32'hAA223344, 0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

    // reset while port0 is stalled in a write data phase
    apply(v(2'b11, 2'b11, 'h40, 'h80, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0), "rst_s0");
    apply(v(2'b01, 2'b01, 'h44, 0, 2, 2, 32'h11111111, 32'h22222222, 2'b11, 2'b00, 2'b00, 0, 0),
          "rst_s1");
    drive2(v(2'b00, 2'b00, 0, 0, 2, 2, 32'h33333333, 0, 2'b10, 2'b00, 2'b00, 0, 0));
    @(negedge hclk);
    check("rst_stall hready", 128'(hready2), 128'(2'b10));
    hresetn = 1'b0;
    #1;
    check("rst_mid hready", 128'(hready2), 128'(2'b11));
    check("rst_mid hresp", 128'(hresp2), 128'(2'b00));
    drive2(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0));
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    tick();
    apply(v(2'b11, 2'b00, 'h40, 'h80, 2, 2, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0), "rst_rd0");
    apply(v(2'b01, 2'b00, 'h44, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b11, A0, B0), "rst_rd1");
    apply(v(2'b00, 2'b00, 0, 0, 2, 2, 0, 0, 2'b11, 2'b00, 2'b01, A1, 0), "rst_rd2");

    // 4-port: halfword from port3 and byte from port2 both pending under a port0 read
    idle4(); drive4(0, 1'b1, 1'b1, 'h20, 3'd2);
    tick();
    idle4(); hwdata4[31:0] = 32'h11223344;
    tick();
    idle4();
    tick();
    drive4(3, 1'b1, 1'b1, 'h22, 3'd1);
    drive4(2, 1'b1, 1'b1, 'h20, 3'd0);
    tick();
    idle4();
    hwdata4[127:96] = 32'hBEEF0000;
    hwdata4[95:64]  = 32'h0000005A;
    drive4(0, 1'b1, 1'b0, 'h20, 3'd2);
    @(negedge hclk);
    check("p4 wdata hready", 128'(hready4), 128'(4'hf));
    tick();
    for (int k = 0; k < 3; k++) begin
      idle4();
      if (k < 2) drive4(0, 1'b1, 1'b0, 'h20, 3'd2);
      @(negedge hclk);
      check($sformatf("p4 merge%0d", k), 128'(hrdata4[31:0]), 128'(32'hBEEF335A));
      check($sformatf("p4 hready%0d", k), 128'(hready4), 128'(4'hf));
      if (k == 0) check("p4 idle hrdata", 128'(hrdata4[127:32]), 128'(0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
